// File: rtl/spi_slave_mlf.sv
// SPI slave: oversamples SCK/MOSI/CS_n in the i_clk domain and exchanges bytes in any SPI mode.
// Optional `SPI_SLAVE_MLF_LSB_FIRST_EN` switches both directions to LSB-first.
module spi_slave_mlf #(
  parameter int SPI_MODE = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_TX_byte,
  input  logic       i_TX_DV,
  output logic       o_TX_ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_byte,
  input  logic       i_SPI_clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_oe
);

`ifdef SPI_SLAVE_MLF_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam bit CPOL        = SPI_MODE[1];
  localparam bit CPHA        = SPI_MODE[0];
  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic [1:0] csn_q;
  state_t     state;
  logic [2:0] cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] hold;
  logic       hold_full;

  logic       rise, fall, sample_edge, shift_edge, cs_act, byte_start;
  logic [7:0] rx_nxt, start_val;

  function automatic logic tx_bit(input logic [7:0] v);
    return LSB_FIRST ? v[0] : v[7];
  endfunction

  function automatic logic [7:0] tx_adv(input logic [7:0] v);
    return LSB_FIRST ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_q  <= '0;
      mosi_q <= '0;
      csn_q  <= 2'b11;
    end else begin
      sck_q  <= {sck_q[1:0], i_SPI_clk};
      mosi_q <= {mosi_q[0], i_SPI_MOSI};
      csn_q  <= {csn_q[0], i_SPI_CS_n};
    end
  end

  assign rise        = sck_q[1] & ~sck_q[2];
  assign fall        = ~sck_q[1] & sck_q[2];
  assign sample_edge = SAMPLE_RISE ? rise : fall;
  assign shift_edge  = SAMPLE_RISE ? fall : rise;
  assign cs_act      = ~csn_q[1];
  assign rx_nxt      = LSB_FIRST ? {mosi_q[1], rx_sr[7:1]} : {rx_sr[6:0], mosi_q[1]};
  assign start_val   = hold_full ? hold : 8'h00;
  assign byte_start  = cs_act && ((state == IDLE) ||
                                  (sample_edge && cnt == 3'd7));
  assign o_TX_ready  = ~hold_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_byte     <= '0;
      o_SPI_MISO    <= 1'b0;
      o_SPI_MISO_oe <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (i_TX_DV && !hold_full) begin
        hold      <= i_TX_byte;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cs_act) begin
            state         <= ACTIVE;
            o_SPI_MISO_oe <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!cs_act) begin
            // Abort: partial byte and TX shift contents are dropped, holder kept.
            state         <= IDLE;
            o_SPI_MISO_oe <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            cnt           <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
          end else if (sample_edge) begin
            rx_sr <= rx_nxt;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              o_RX_byte <= rx_nxt;
              o_RX_DV   <= 1'b1;
            end
          end else if (shift_edge && (CPHA || cnt != 3'd0)) begin
            // CPHA=0 already presented the first bit at byte start, so the
            // trailing edge after the 8th sample must not advance the new byte.
            o_SPI_MISO <= tx_bit(tx_sr);
            tx_sr      <= tx_adv(tx_sr);
          end
        end
        default: state <= IDLE;
      endcase
      if (byte_start) begin
        if (CPHA) begin
          tx_sr <= start_val;
        end else begin
          tx_sr      <= tx_adv(start_val);
          o_SPI_MISO <= tx_bit(start_val);
        end
        if (hold_full) hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Bench for spi_slave_mlf: one DUT per SPI mode driven by a behavioural master.
module tb_spi_slave_mlf;

  localparam int H = 4;
`ifdef SPI_SLAVE_MLF_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sck, mosi, cs_n, tx_dv, tx_ready, rx_dv, miso, oe;
  logic [3:0][7:0] tx_byte, rx_byte;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_mlf #(.SPI_MODE(g)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_TX_byte(tx_byte[g]), .i_TX_DV(tx_dv[g]), .o_TX_ready(tx_ready[g]),
      .o_RX_DV(rx_dv[g]), .o_RX_byte(rx_byte[g]),
      .i_SPI_clk(sck[g]), .i_SPI_MOSI(mosi[g]), .i_SPI_CS_n(cs_n[g]),
      .o_SPI_MISO(miso[g]), .o_SPI_MISO_oe(oe[g]));
  end

  logic [7:0] rx_log [4][64];
  int rx_cnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rx_dv[i] === 1'b1 && rx_cnt[i] < 64) begin
        rx_log[i][rx_cnt[i]] = rx_byte[i];
        rx_cnt[i] = rx_cnt[i] + 1;
      end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic m_first;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic mbit(input int i);
    int k, j;
    k = i / 8;
    j = i % 8;
    return LSB ? m_tx[k][j] : m_tx[k][7-j];
  endfunction

  task automatic rx_bit(input int i, input logic v);
    int k, j;
    k = i / 8;
    j = i % 8;
    if (LSB) m_rx[k][j] = v;
    else     m_rx[k][7-j] = v;
    if (i == 0) m_first = v;
  endtask

  // Master: H i_clk cycles per half bit, H cycles CS setup, nbits then CS high.
  task automatic spi_xfer(input int m, input int nbits);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    for (int k = 0; k < 4; k++) m_rx[k] = 8'h00;
    cs_n[m] = 1'b0;
    if (!cpha) mosi[m] = mbit(0);
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sck[m] = ~cpol; rx_bit(i, miso[m]); wait_clk(H);
        sck[m] = cpol;  if (i + 1 < nbits) mosi[m] = mbit(i + 1); wait_clk(H);
      end else begin
        sck[m] = ~cpol; mosi[m] = mbit(i); wait_clk(H);
        sck[m] = cpol;  rx_bit(i, miso[m]); wait_clk(H);
      end
    end
    cs_n[m] = 1'b1;
    mosi[m] = 1'b0;
    wait_clk(8);
  endtask

  task automatic load_tx(input int m, input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 200) begin wait_clk(1); t++; end
    chk("load_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
    tx_byte[m] = b;
    tx_dv[m] = 1'b1;
    wait_clk(1);
    tx_dv[m] = 1'b0;
  endtask

  typedef struct {
    int         mode;
    bit         pre;
    logic [7:0] pre_b;
    logic [7:0] mosi_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int base;
    tbl[0] = '{3, 1'b1, 8'h3A, 8'hC1, 8'hC1, 8'h3A};
    tbl[1] = '{0, 1'b1, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
    tbl[2] = '{1, 1'b1, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
    tbl[3] = '{2, 1'b1, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
    tbl[4] = '{3, 1'b1, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
    tbl[5] = '{3, 1'b0, 8'h00, 8'h77, 8'h77, 8'h00};
    tbl[6] = '{0, 1'b0, 8'h00, 8'h77, 8'h77, 8'h00};

    sck = 4'b1100;
    mosi = '0;
    cs_n = '1;
    tx_dv = '0;
    tx_byte = '0;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      chk("reset_rx_dv", {31'd0, rx_dv[m]}, 32'd0);
      chk("reset_rx_byte", {24'd0, rx_byte[m]}, 32'd0);
      chk("reset_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
      chk("reset_miso", {31'd0, miso[m]}, 32'd0);
      chk("reset_miso_oe", {31'd0, oe[m]}, 32'd0);
    end
    rst_n = 1'b1;
    wait_clk(5);

    for (int v = 0; v < 7; v++) begin
      int m;
      m = tbl[v].mode;
      base = rx_cnt[m];
      if (tbl[v].pre) load_tx(m, tbl[v].pre_b);
      m_tx[0] = tbl[v].mosi_b;
      spi_xfer(m, 8);
      chk($sformatf("vec%0d_rx_count", v), rx_cnt[m] - base, 32'd1);
      chk($sformatf("vec%0d_rx_byte", v), {24'd0, rx_log[m][base]}, {24'd0, tbl[v].exp_rx});
      chk($sformatf("vec%0d_master_rx", v), {24'd0, m_rx[0]}, {24'd0, tbl[v].exp_miso});
      chk($sformatf("vec%0d_tx_ready", v), {31'd0, tx_ready[m]}, 32'd1);
      chk($sformatf("vec%0d_oe_idle", v), {31'd0, oe[m]}, 32'd0);
    end

    // Back-to-back under one CS, second TX byte loaded on the ready rise.
    for (int m = 0; m < 4; m += 3) begin
      base = rx_cnt[m];
      load_tx(m, 8'h12);
      m_tx[0] = 8'hBE;
      m_tx[1] = 8'hEF;
      fork
        spi_xfer(m, 16);
        begin
          int t;
          t = 0;
          while (tx_ready[m] !== 1'b1 && t < 100) begin wait_clk(1); t++; end
          chk("b2b_ready_rise", {31'd0, tx_ready[m]}, 32'd1);
          load_tx(m, 8'h34);
        end
      join
      chk("b2b_rx_count", rx_cnt[m] - base, 32'd2);
      chk("b2b_rx0", {24'd0, rx_log[m][base]}, 32'hBE);
      chk("b2b_rx1", {24'd0, rx_log[m][base+1]}, 32'hEF);
      chk("b2b_master_rx0", {24'd0, m_rx[0]}, 32'h12);
      chk("b2b_master_rx1", {24'd0, m_rx[1]}, 32'h34);
    end

    // CS abort after 4 bits; holder loaded during the aborted byte survives.
    base = rx_cnt[0];
    m_tx[0] = 8'hFF;
    fork
      spi_xfer(0, 4);
      begin wait_clk(10); load_tx(0, 8'h55); end
    join
    chk("abort_no_rx_dv", rx_cnt[0] - base, 32'd0);
    chk("abort_holder_kept", {31'd0, tx_ready[0]}, 32'd0);
    chk("abort_oe_idle", {31'd0, oe[0]}, 32'd0);
    m_tx[0] = 8'h81;
    spi_xfer(0, 8);
    chk("abort_next_rx_count", rx_cnt[0] - base, 32'd1);
    chk("abort_next_rx", {24'd0, rx_log[0][base]}, 32'h81);
    chk("abort_next_master_rx", {24'd0, m_rx[0]}, 32'h55);

    // Bit order: 0x01 both ways.
    base = rx_cnt[3];
    load_tx(3, 8'h01);
    m_tx[0] = 8'h01;
    spi_xfer(3, 8);
    chk("order_first_miso_bit", {31'd0, m_first}, {31'd0, LSB});
    chk("order_rx", {24'd0, rx_log[3][base]}, 32'h01);
    chk("order_master_rx", {24'd0, m_rx[0]}, 32'h01);

    // Asynchronous reset in the middle of a byte.
    load_tx(0, 8'h3A);
    m_tx[0] = 8'hC3;
    fork
      spi_xfer(0, 8);
      begin
        wait_clk(10);
        load_tx(0, 8'hEE);
        wait_clk(15);
        chk("midrst_oe_before", {31'd0, oe[0]}, 32'd1);
        chk("midrst_ready_before", {31'd0, tx_ready[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_dv", {31'd0, rx_dv[0]}, 32'd0);
        chk("midrst_rx_byte", {24'd0, rx_byte[0]}, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("midrst_miso", {31'd0, miso[0]}, 32'd0);
        chk("midrst_miso_oe", {31'd0, oe[0]}, 32'd0);
      end
    join
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
